// File: rtl/reg_file_mp_sb_if.sv
// Decode/writeback bus of the dual-write-port register file with busy scoreboard.
// master = CPU pipeline side, slave = register file.
interface reg_file_mp_sb_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  wen0;
  logic [ADDR_WIDTH-1:0] waddr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  wen1;
  logic [ADDR_WIDTH-1:0] waddr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [DATA_WIDTH-1:0] rdata2;
  logic                  rbusy1;
  logic                  rbusy2;
  logic                  bset;
  logic [ADDR_WIDTH-1:0] baddr;
  logic [ADDR_WIDTH:0]   busy_cnt;

  modport master (
    output wen0, waddr0, wdata0, wen1, waddr1, wdata1,
    output raddr1, raddr2, bset, baddr,
    input  rdata1, rdata2, rbusy1, rbusy2, busy_cnt
  );

  modport slave (
    input  wen0, waddr0, wdata0, wen1, waddr1, wdata1,
    input  raddr1, raddr2, bset, baddr,
    output rdata1, rdata2, rbusy1, rbusy2, busy_cnt
  );
endinterface

// File: rtl/reg_file_mp_sb.sv
// Register file: two write ports (port 1 wins on collision), two async read ports,
// per-register busy scoreboard with registered popcount. Define REG_FILE_BYPASS_EN for same-cycle write forwarding.
module reg_file_mp_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 1
) (
  input logic               clk,
  input logic               rst,
  reg_file_mp_sb_if.slave   bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam bit          ZR    = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_nxt;
  logic [CW-1:0]         cnt_nxt;
  logic                  we0;
  logic                  we1;

  // Writes to the hard-wired zero register are dropped.
  assign we0 = bus.wen0 && !(ZR && (bus.waddr0 == '0));
  assign we1 = bus.wen1 && !(ZR && (bus.waddr1 == '0));

  // Scoreboard next state: issue (set) beats writeback (clear).
  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ZR && (i == 0)) begin
        busy_nxt[i] = 1'b0;
      end else if (bus.bset && (bus.baddr == ADDR_WIDTH'(i))) begin
        busy_nxt[i] = 1'b1;
      end else if ((bus.wen0 && (bus.waddr0 == ADDR_WIDTH'(i))) ||
                   (bus.wen1 && (bus.waddr1 == ADDR_WIDTH'(i)))) begin
        busy_nxt[i] = 1'b0;
      end
      cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy         <= '0;
      bus.busy_cnt <= '0;
    end else begin
      if (we0) regs[bus.waddr0] <= bus.wdata0;
      if (we1) regs[bus.waddr1] <= bus.wdata1;
      busy         <= busy_nxt;
      bus.busy_cnt <= cnt_nxt;
    end
  end

  logic [ADDR_WIDTH-1:0] ra [2];
  logic [DATA_WIDTH-1:0] rd [2];
  logic                  rb [2];

  assign ra[0] = bus.raddr1;
  assign ra[1] = bus.raddr2;

  for (genvar k = 0; k < 2; k++) begin : g_rd
`ifdef REG_FILE_BYPASS_EN
    logic hit0;
    logic hit1;
    logic reissue;
    assign hit0    = bus.wen0 && (bus.waddr0 == ra[k]);
    assign hit1    = bus.wen1 && (bus.waddr1 == ra[k]);
    assign reissue = bus.bset && (bus.baddr == ra[k]);
`endif
    always_comb begin
      rd[k] = regs[ra[k]];
      rb[k] = busy[ra[k]];
`ifdef REG_FILE_BYPASS_EN
      if (hit1) begin
        rd[k] = bus.wdata1;
      end else if (hit0) begin
        rd[k] = bus.wdata0;
      end
      // Forwarded value is final unless a new producer is issued this cycle.
      if ((hit0 || hit1) && !reissue) begin
        rb[k] = 1'b0;
      end
`endif
      if (ZR && (ra[k] == '0)) begin
        rd[k] = '0;
        rb[k] = 1'b0;
      end
    end
  end

  assign bus.rdata1 = rd[0];
  assign bus.rdata2 = rd[1];
  assign bus.rbusy1 = rb[0];
  assign bus.rbusy2 = rb[1];
endmodule

// File: tb/tb_reg_file_mp_sb.sv
// Directed bench for reg_file_mp_sb; expectations follow REG_FILE_BYPASS_EN if defined.
module tb_reg_file_mp_sb;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  reg_file_mp_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  reg_file_mp_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wen0 = 1'b0; bus.waddr0 = '0; bus.wdata0 = '0;
    bus.wen1 = 1'b0; bus.waddr1 = '0; bus.wdata1 = '0;
    bus.bset = 1'b0; bus.baddr = '0;
  endtask

  logic [DW-1:0] exp_d;
  logic          exp_b;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    bus.raddr1 = 5'd5;
    bus.raddr2 = 5'd31;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_cnt",    64'(bus.busy_cnt), 64'd0);
    check("reset_rdata1", 64'(bus.rdata1),   64'd0);
    check("reset_rdata2", 64'(bus.rdata2),   64'd0);
    check("reset_rbusy1", 64'(bus.rbusy1),   64'd0);

    // Port 0 write, visible next cycle (or same cycle with forwarding)
    bus.wen0 = 1'b1; bus.waddr0 = 5'd5; bus.wdata0 = 32'hDEADBEEF;
    #1;
`ifdef REG_FILE_BYPASS_EN
    exp_d = 32'hDEADBEEF;
`else
    exp_d = 32'h0;
`endif
    check("wr0_same_cycle", 64'(bus.rdata1), 64'(exp_d));
    tick();
    idle();
    #1;
    check("wr0_next_cycle", 64'(bus.rdata1), 64'h0000_0000_DEAD_BEEF);

    // Both ports to reg 7: port 1 wins
    bus.raddr2 = 5'd7;
    bus.wen0 = 1'b1; bus.waddr0 = 5'd7; bus.wdata0 = 32'h11;
    bus.wen1 = 1'b1; bus.waddr1 = 5'd7; bus.wdata1 = 32'h22;
    #1;
`ifdef REG_FILE_BYPASS_EN
    exp_d = 32'h22;
`else
    exp_d = 32'h0;
`endif
    check("collide_same_cycle", 64'(bus.rdata2), 64'(exp_d));
    tick();
    idle();
    #1;
    check("collide_port1_wins", 64'(bus.rdata2), 64'h22);

    // Zero register ignores write and bset
    bus.raddr1 = 5'd0;
    bus.wen1 = 1'b1; bus.waddr1 = 5'd0; bus.wdata1 = 32'hFFFFFFFF;
    bus.bset = 1'b1; bus.baddr = 5'd0;
    #1;
    check("zero_same_cycle", 64'(bus.rdata1), 64'd0);
    tick();
    idle();
    #1;
    check("zero_rdata", 64'(bus.rdata1), 64'd0);
    check("zero_rbusy", 64'(bus.rbusy1), 64'd0);
    check("zero_cnt",   64'(bus.busy_cnt), 64'd0);

    // Scoreboard set / clear on reg 3
    bus.raddr1 = 5'd3;
    bus.raddr2 = 5'd4;
    bus.bset = 1'b1; bus.baddr = 5'd3;
    #1;
    check("bset_not_yet_busy", 64'(bus.rbusy1), 64'd0);
    tick();
    idle();
    #1;
    check("bset3_rbusy1",   64'(bus.rbusy1),   64'd1);
    check("bset3_rbusy2_4", 64'(bus.rbusy2),   64'd0);
    check("bset3_cnt",      64'(bus.busy_cnt), 64'd1);

    bus.wen1 = 1'b1; bus.waddr1 = 5'd3; bus.wdata1 = 32'h33;
    #1;
`ifdef REG_FILE_BYPASS_EN
    exp_b = 1'b0;
    exp_d = 32'h33;
`else
    exp_b = 1'b1;
    exp_d = 32'h0;
`endif
    check("clr3_same_rbusy", 64'(bus.rbusy1), 64'(exp_b));
    check("clr3_same_rdata", 64'(bus.rdata1), 64'(exp_d));
    tick();
    idle();
    #1;
    check("clr3_rbusy", 64'(bus.rbusy1),   64'd0);
    check("clr3_cnt",   64'(bus.busy_cnt), 64'd0);
    check("clr3_rdata", 64'(bus.rdata1),   64'h33);

    // Set beats clear in the same cycle
    bus.bset = 1'b1; bus.baddr = 5'd3;
    bus.wen0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 32'h44;
    tick();
    idle();
    #1;
    check("setclr_rbusy", 64'(bus.rbusy1),   64'd1);
    check("setclr_cnt",   64'(bus.busy_cnt), 64'd1);
    check("setclr_rdata", 64'(bus.rdata1),   64'h44);

    // Write to non-busy register leaves scoreboard alone
    bus.raddr2 = 5'd9;
    bus.wen0 = 1'b1; bus.waddr0 = 5'd9; bus.wdata0 = 32'h99;
    tick();
    idle();
    #1;
    check("nb_rdata", 64'(bus.rdata2),   64'h99);
    check("nb_rbusy", 64'(bus.rbusy2),   64'd0);
    check("nb_cnt",   64'(bus.busy_cnt), 64'd1);

    bus.wen0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 32'h55;
    tick();
    idle();
    #1;
    check("clr3b_cnt", 64'(bus.busy_cnt), 64'd0);

    // Fill the scoreboard: regs 1..31, count trails by one cycle
    for (int i = 1; i < 32; i++) begin
      bus.bset = 1'b1; bus.baddr = AW'(i);
      #1;
      check("fill_cnt", 64'(bus.busy_cnt), 64'(i - 1));
      tick();
    end
    idle();
    #1;
    check("fill_cnt_31", 64'(bus.busy_cnt), 64'd31);

    bus.bset = 1'b1; bus.baddr = 5'd5;
    tick();
    idle();
    bus.raddr1 = 5'd17;
    bus.raddr2 = 5'd20;
    #1;
    check("rebset_cnt",    64'(bus.busy_cnt), 64'd31);
    check("fill_rbusy17",  64'(bus.rbusy1),   64'd1);

    // Both ports clear distinct registers in one cycle
    bus.wen0 = 1'b1; bus.waddr0 = 5'd10; bus.wdata0 = 32'hA0;
    bus.wen1 = 1'b1; bus.waddr1 = 5'd20; bus.wdata1 = 32'hB0;
    tick();
    idle();
    #1;
    check("dualclr_cnt",    64'(bus.busy_cnt), 64'd29);
    check("dualclr_rbusy2", 64'(bus.rbusy2),   64'd0);
    check("dualclr_rdata2", 64'(bus.rdata2),   64'hB0);

    // Reset mid-sequence: concurrent write/bset are ignored
    rst = 1'b1;
    bus.bset = 1'b1; bus.baddr = 5'd10;
    bus.wen0 = 1'b1; bus.waddr0 = 5'd5; bus.wdata0 = 32'h1234;
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("rst2_cnt", 64'(bus.busy_cnt), 64'd0);
    for (int i = 0; i < 32; i++) begin
      bus.raddr1 = AW'(i);
      bus.raddr2 = AW'(31 - i);
      #1;
      check("rst2_rdata1", 64'(bus.rdata1), 64'd0);
      check("rst2_rbusy1", 64'(bus.rbusy1), 64'd0);
      check("rst2_rbusy2", 64'(bus.rbusy2), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
